// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the pipelined MIPS32 codebase.
// - WORD_W / IMEM_ERR_WORD: instruction word width and the word returned for a
//   fetch outside instruction memory.
// - Opcode constants, used by benches to assemble test programs.
// - imem_rsp_t: one instruction-memory response (error flag + word).
package pipe_mips32_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] IMEM_ERR_WORD = 32'h0;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] HLT   = 6'b111111;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] data;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response buffer for the instruction-memory responder.
// FIFO_DEPTH entries of imem_rsp_t, synchronous push/pop, synchronous clear.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// FIFO_DEPTH must be a power of two and at least 2.
// Ports:
//   clk1, rst_n          clock, asynchronous active-low reset
//   clear                drop all entries (pointer reset)
//   push, push_data      write one entry
//   pop                  discard the head entry
//   pop_data             head entry (undefined when empty)
//   empty, full, count   occupancy status
module imem_rsp_fifo
  import pipe_mips32_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  imem_rsp_t   push_data,
  input  logic        pop,
  output imem_rsp_t   pop_data,
  output logic        empty,
  output logic        full,
  output logic [PW:0] count
);

  imem_rsp_t   mem_q [FIFO_DEPTH];
  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; occupancy is tracked by the pointers only.
  always_ff @(posedge clk1) begin
    if (push && !clear) mem_q[wptr_q[PW-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rptr_q[PW-1:0]];
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign count    = wptr_q - rptr_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: memory end of the IF-stage fetch interface.
// Accepts word-address fetches, returns instruction words LATENCY cycles later
// in request order through a response buffer, with backpressure, branch flush
// and a program-load side port.
// Ports:
//   clk1, rst_n                     clock, asynchronous active-low reset
//   req_valid, req_addr, req_ready  fetch request handshake (word address)
//   rsp_valid, rsp_ready            response handshake
//   rsp_data, rsp_err               instruction word, out-of-range flag
//   flush                           drop every outstanding fetch
//   ld_en, ld_addr, ld_data         program-load write port
module imem_fetch_responder
  import pipe_mips32_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [WORD_W-1:0]        req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_W-1:0]        rsp_data,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WORD_W-1:0]        ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0]          mem_q [DEPTH];
  logic                       ready_en_q;
  logic [CW-1:0]              outstanding_q, outstanding_d;
  logic [LATENCY-1:0]         pipe_vld_q, pipe_vld_d;
  imem_rsp_t [LATENCY-1:0]    pipe_q;
  imem_rsp_t                  rd_word;
  imem_rsp_t                  fifo_head;
  logic                       fifo_empty, fifo_full, fifo_push;
  logic [CW-1:0]              fifo_count;
  logic                       in_range, accept, pop;

  assign in_range = (req_addr < WORD_W'(DEPTH));

  // ready_en_q holds req_ready low while in reset and until the first edge after it.
  // The credit limit counts both pipeline and buffer, so the buffer cannot overflow.
  assign req_ready = ready_en_q && !flush && (outstanding_q < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign fifo_push = pipe_vld_q[LATENCY-1] && !flush;
  assign rsp_data  = rsp_valid ? fifo_head.data : '0;
  assign rsp_err   = rsp_valid && fifo_head.err;

  // Out-of-range fetches never index the array.
  always_comb begin
    rd_word.err  = !in_range;
    rd_word.data = IMEM_ERR_WORD;
    if (in_range) rd_word.data = mem_q[req_addr[AW-1:0]];
  end

  // Array and pipeline payload are not reset. Reading before the same-edge
  // write gives read-first behaviour for a load/fetch collision.
  always_ff @(posedge clk1) begin
    if (ld_en)  mem_q[ld_addr] <= ld_data;
    if (accept) pipe_q[0] <= rd_word;
    for (int unsigned k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
  end

  always_comb begin
    pipe_vld_d[0] = accept;
    for (int unsigned k = 1; k < LATENCY; k++) pipe_vld_d[k] = pipe_vld_q[k-1];
    if (flush) pipe_vld_d = '0;
  end

  always_comb begin
    outstanding_d = outstanding_q + CW'(accept) - CW'(pop);
    if (flush) outstanding_d = '0;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q    <= 1'b0;
      outstanding_q <= '0;
      pipe_vld_q    <= '0;
    end else begin
      ready_en_q    <= 1'b1;
      outstanding_q <= outstanding_d;
      pipe_vld_q    <= pipe_vld_d;
    end
  end

  imem_rsp_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (fifo_push),
    .push_data(pipe_q[LATENCY-1]),
    .pop      (pop),
    .pop_data (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  a_no_overflow : assert property (@(posedge clk1) disable iff (!rst_n)
    !(fifo_full && fifo_push));
  a_credit_covers_fifo : assert property (@(posedge clk1) disable iff (!rst_n)
    fifo_count <= outstanding_q);

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;
  import pipe_mips32_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned FD    = 4;

  logic        clk1 = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic        flush, ld_en;
  logic [31:0] req_addr, rsp_data, ld_data;
  logic [9:0]  ld_addr;

  imem_fetch_responder #(
    .DEPTH     (DEPTH),
    .LATENCY   (LAT),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always #5 clk1 = ~clk1;

  // Reference model: program memory, plus a queue of every fetch still owed
  // to the IF stage with the cycle from which it may be presented.
  typedef struct {
    logic [32:0] rsp;
    int unsigned due;
  } exp_t;

  logic [31:0] mem_m [DEPTH];
  exp_t        sb [$];
  int unsigned cyc = 0;
  bit          armed = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [5:0]  ops [6];

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: runs mid-cycle, compares what the DUT presents with
  // the model, then applies what the coming edge will do to the model.
  always @(negedge clk1) begin
    bit   exp_ready, exp_valid;
    exp_t e;
    if (!rst_n) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data_err", 64'({rsp_err, rsp_data}), 64'd0);
      sb.delete();
      armed = 1'b0;
    end else begin
      exp_ready = armed && (sb.size() < FD) && !flush;
      exp_valid = (sb.size() > 0) && (cyc >= sb[0].due);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      if (exp_valid) check("rsp_err_data", 64'({rsp_err, rsp_data}), 64'(sb[0].rsp));
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_valid && rsp_ready) void'(sb.pop_front());
        if (req_valid && exp_ready) begin
          if (req_addr >= DEPTH) e.rsp = {1'b1, 32'h0};
          else                   e.rsp = {1'b0, mem_m[req_addr[9:0]]};
          e.due = cyc + 1 + LAT;
          sb.push_back(e);
        end
      end
      if (ld_en) mem_m[ld_addr] = ld_data;
      armed = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic load(input int unsigned a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = 10'(a);
    ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    check("drain_done", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    ops = '{RTYPE, ADDI, LW, SW, BEQ, HLT};
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();

    // Fill the whole program memory with random instructions.
    for (int i = 0; i < DEPTH; i++) load(i, {ops[$urandom_range(0, 5)], 26'($urandom)});
    load(0, 32'h0000_1111);
    load(1, 32'h0000_2222);
    load(2, 32'h0000_3333);
    load(3, 32'h0000_4444);
    load(10, {HLT, 26'h0});
    load(7, 32'hAAAA_AAAA);

    // Back-to-back fetch of the preloaded words.
    rsp_ready = 1'b1;
    for (int a = 0; a < 4; a++) fetch(32'(a));
    drain();

    // Backpressure: only FD fetches accepted until the first pop.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(20 + i);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(26 + i);
      step();
    end
    drain();

    // Flush with three fetches in flight; branch target re-presented after.
    rsp_ready = 1'b0;
    for (int a = 30; a < 33; a++) fetch(32'(a));
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'd10;
    step();
    flush = 1'b0; rsp_ready = 1'b1;
    fetch(32'd10);
    drain();

    // Out of range followed by an in-range fetch.
    fetch(32'd1024);
    fetch(32'd5);
    drain();

    // Load/fetch collision on the same word.
    ld_en = 1'b1; ld_addr = 10'd7; ld_data = 32'hBBBB_BBBB;
    fetch(32'd7);
    ld_en = 1'b0;
    fetch(32'd7);
    drain();

    // Randomised traffic; loads avoid words 0..3 so they stay known.
    for (int i = 0; i < 600; i++) begin
      int unsigned r = $urandom_range(0, 99);
      req_valid = ($urandom_range(0, 99) < 70);
      if (r < 6)       req_addr = 32'($urandom_range(1024, 1100));
      else if (r < 8)  req_addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else             req_addr = 32'($urandom_range(0, 1023));
      rsp_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 4);
      ld_en     = ($urandom_range(0, 99) < 15);
      ld_addr   = 10'($urandom_range(4, 1023));
      ld_data   = $urandom;
      step();
    end
    drain();

    // Reset with fetches split between pipeline and buffer.
    rsp_ready = 1'b0;
    for (int a = 40; a < 44; a++) fetch(32'(a));
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_req_ready", 64'(req_ready), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    rsp_ready = 1'b1;
    fetch(32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
